// File: rtl/qsys_basic_mod0_dac0.sv
// Avalon-MM sample port feeding a 16-bit MSB-first SPI DAC through a small FIFO.
// Latency: readdata 1 cycle; first frame starts 1 cycle after a write to an empty FIFO.
// Backpressure: none on Avalon; a push into a full FIFO is dropped and flagged as overflow.

module dac_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    // Fullness is judged before the same-cycle pop, so a push into a full FIFO always drops.
    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// Avalon-MM slave that serializes queued 12-bit samples to an SPI DAC (mode 0).
// Latency: readdata registered, 1 cycle; writes complete in the presented cycle.
// Backpressure: none; overflow is sticky until cleared through STATUS bit 8.
module qsys_basic_mod0_dac0 #(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         DEFAULT_DIV = 4,
    parameter logic [3:0] CMD_BITS    = 4'h3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_mosi
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t      state, state_nxt;
    logic [11:0] last;
    logic        overflow;
    logic [7:0]  div;
    logic [7:0]  div_l;
    logic [7:0]  cnt;
    logic [3:0]  bit_idx;
    logic [15:0] sh;
    logic        pop;
    logic        half_done;

    logic        wr_data;
    logic        wr_stat;
    logic        wr_div;
    logic [11:0] fifo_dat;
    logic        fifo_full;
    logic        fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [4:0]  lvl5;
    logic [3:0]  lvl4;
    logic [15:0] frame;
    logic        unused_sigs;

    assign wr_data     = write && (address == 3'd0);
    assign wr_stat     = write && (address == 3'd1);
    assign wr_div      = write && (address == 3'd2);
    assign frame       = {CMD_BITS, fifo_dat};
    assign lvl5        = 5'(fifo_level);
    assign lvl4        = lvl5[4] ? 4'hF : lvl5[3:0];
    assign half_done   = (cnt == div_l);
    assign unused_sigs = &{1'b0, read, writedata[31:12]};

    dac_fifo #(.WIDTH(12), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (wr_data),
        .push_dat (writedata[11:0]),
        .pop_rdy  (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (half_done && dac_sclk && (bit_idx == 4'd15)) state_nxt = GAP;
            end
            GAP: begin
                if (half_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // dac_sclk doubles as the half-period phase: low half then high half per bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dac_cs_n <= 1'b1;
            dac_sclk <= 1'b0;
            dac_mosi <= 1'b0;
            div_l    <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            sh       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pop) begin
                        sh       <= {frame[14:0], 1'b0};
                        dac_mosi <= frame[15];
                        dac_cs_n <= 1'b0;
                        dac_sclk <= 1'b0;
                        div_l    <= div;
                        bit_idx  <= '0;
                    end
                end
                SHIFT: begin
                    if (half_done) begin
                        cnt      <= '0;
                        dac_sclk <= ~dac_sclk;
                        if (dac_sclk) begin
                            if (bit_idx == 4'd15) begin
                                dac_cs_n <= 1'b1;
                                dac_mosi <= 1'b0;
                            end else begin
                                bit_idx  <= bit_idx + 1'b1;
                                dac_mosi <= sh[15];
                                sh       <= {sh[14:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last     <= '0;
            overflow <= 1'b0;
            div      <= 8'(DEFAULT_DIV);
        end else begin
            if (wr_data) last <= writedata[11:0];
            if (wr_div)  div  <= writedata[7:0];
            // Set takes priority over a same-cycle clear.
            if (wr_data && fifo_full)           overflow <= 1'b1;
            else if (wr_stat && writedata[8])   overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                3'd0:    readdata <= {20'b0, last};
                3'd1:    readdata <= {23'b0, overflow, lvl4, 1'b0, fifo_empty, fifo_full,
                                      (state != IDLE)};
                3'd2:    readdata <= {24'b0, div};
                default: readdata <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_qsys_basic_mod0_dac0.sv
// Directed bench for qsys_basic_mod0_dac0: register map, SPI framing/timing, overflow, reset abort.
module tb_qsys_basic_mod0_dac0;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        dac_cs_n;
    logic        dac_sclk;
    logic        dac_mosi;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    qsys_basic_mod0_dac0 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .read      (read),
        .readdata  (readdata),
        .dac_cs_n  (dac_cs_n),
        .dac_sclk  (dac_sclk),
        .dac_mosi  (dac_mosi)
    );

    always #5 clk = ~clk;

    // SPI monitor, sampled on the falling clk edge away from the DUT's active edge.
    int          cyc = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    int          mon_bits = 0;
    logic [15:0] mon_fr = '0;
    int          fall_cyc = 0;
    int          sclk_rises = 0;
    int          cs_falls = 0;
    logic [15:0] frames[$];
    int          lows[$];
    int          falls[$];
    int          nbits[$];

    always @(negedge clk) begin
        cyc++;
        if (prev_cs && !dac_cs_n) begin
            fall_cyc = cyc;
            mon_bits = 0;
            mon_fr   = '0;
            falls.push_back(cyc);
            cs_falls++;
        end
        if (!prev_sclk && dac_sclk) begin
            mon_fr = {mon_fr[14:0], dac_mosi};
            mon_bits++;
            sclk_rises++;
        end
        if (!prev_cs && dac_cs_n && reset_n) begin
            frames.push_back(mon_fr);
            lows.push_back(cyc - fall_cyc);
            nbits.push_back(mon_bits);
        end
        prev_cs   = dac_cs_n;
        prev_sclk = dac_sclk;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Tasks start and end on a falling clk edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        d       = readdata;
        read    = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int i;
        i = 0;
        while (frames.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("frame_count", frames.size(), n);
    endtask

    task automatic clear_mon();
        frames.delete();
        lows.delete();
        falls.delete();
        nbits.delete();
    endtask

    logic [31:0] r;
    logic [15:0] exp3 [5];
    logic [15:0] exp4 [5];
    int          rises0;
    int          falls0;

    initial begin
        exp3 = '{16'h3111, 16'h3222, 16'h3333, 16'h3444, 16'h3555};
        exp4 = '{16'h30A1, 16'h30A2, 16'h30A3, 16'h30A4, 16'h30A5};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_cs_n", 32'(dac_cs_n), 32'h1);
        chk("rst_sclk", 32'(dac_sclk), 32'h0);
        chk("rst_mosi", 32'(dac_mosi), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        rd(3'd1, r); chk("rst_status", r, 32'h4);
        rd(3'd2, r); chk("rst_clkdiv", r, 32'h4);
        rd(3'd0, r); chk("rst_last", r, 32'h0);
        rd(3'd5, r); chk("unmapped_rd", r, 32'h0);

        // DIV=0 single frame
        clear_mon();
        wr(3'd2, 32'h0);
        wr(3'd0, 32'hABC);
        rd(3'd1, r); chk("lvl_after_push", r, 32'h10);
        rd(3'd1, r); chk("busy_after_pop", r, 32'h5);
        wait_frames(1, 200);
        chk("div0_frame", 32'(frames[0]), 32'h3ABC);
        chk("div0_low", 32'(lows[0]), 32'd32);
        chk("div0_bits", 32'(nbits[0]), 32'd16);
        rd(3'd0, r); chk("last_abc", r, 32'hABC);

        // DIV=3, five back-to-back samples
        repeat (5) @(negedge clk);
        clear_mon();
        wr(3'd2, 32'h3);
        wr(3'd0, 32'h111);
        wr(3'd0, 32'h222);
        wr(3'd0, 32'h333);
        wr(3'd0, 32'h444);
        wr(3'd0, 32'h555);
        rd(3'd1, r); chk("five_status", r, 32'h43);
        rd(3'd2, r); chk("clkdiv3", r, 32'h3);
        wait_frames(5, 900);
        for (int i = 0; i < 5; i++) begin
            chk("div3_frame", 32'(frames[i]), 32'(exp3[i]));
            chk("div3_low", 32'(lows[i]), 32'd128);
        end
        for (int i = 0; i < 4; i++)
            chk("div3_spacing", 32'(falls[i+1] - falls[i]), 32'd133);

        // Overflow while a frame is active
        repeat (10) @(negedge clk);
        clear_mon();
        wr(3'd0, 32'h0A1);
        wr(3'd0, 32'h0A2);
        wr(3'd0, 32'h0A3);
        wr(3'd0, 32'h0A4);
        wr(3'd0, 32'h0A5);
        wr(3'd0, 32'hBAD);
        rd(3'd1, r); chk("ovf_status", r, 32'h143);
        rd(3'd0, r); chk("ovf_last", r, 32'hBAD);
        wr(3'd1, 32'h100);
        rd(3'd1, r); chk("ovf_cleared", r, 32'h43);
        wait_frames(5, 900);
        repeat (200) @(negedge clk);
        chk("ovf_no_extra", frames.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("ovf_frame", 32'(frames[i]), 32'(exp4[i]));

        // CLKDIV change mid-frame applies to the next frame only
        clear_mon();
        wr(3'd2, 32'h0);
        wr(3'd0, 32'h123);
        wr(3'd0, 32'h456);
        repeat (3) @(negedge clk);
        wr(3'd2, 32'h1);
        wait_frames(2, 300);
        chk("chdiv_frame0", 32'(frames[0]), 32'h3123);
        chk("chdiv_low0", 32'(lows[0]), 32'd32);
        chk("chdiv_frame1", 32'(frames[1]), 32'h3456);
        chk("chdiv_low1", 32'(lows[1]), 32'd64);
        chk("chdiv_spacing", 32'(falls[1] - falls[0]), 32'd34);

        // Asynchronous reset mid-frame
        repeat (10) @(negedge clk);
        clear_mon();
        wr(3'd0, 32'h7FF);
        wr(3'd0, 32'h001);
        begin
            int i;
            i = 0;
            while (!(mon_bits == 7 && !dac_cs_n) && i < 300) begin
                @(negedge clk);
                i++;
            end
            chk("reach_bit7", 32'(mon_bits), 32'd7);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("arst_cs_n", 32'(dac_cs_n), 32'h1);
        chk("arst_sclk", 32'(dac_sclk), 32'h0);
        chk("arst_mosi", 32'(dac_mosi), 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rises0 = sclk_rises;
        falls0 = cs_falls;
        rd(3'd1, r); chk("arst_status", r, 32'h4);
        rd(3'd2, r); chk("arst_clkdiv", r, 32'h4);
        rd(3'd0, r); chk("arst_last", r, 32'h0);
        repeat (100) @(negedge clk);
        chk("arst_no_sclk", 32'(sclk_rises), 32'(rises0));
        chk("arst_no_cs", 32'(cs_falls), 32'(falls0));
        chk("arst_cs_idle", 32'(dac_cs_n), 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
